rip_fetch_queue: RTL and testbench
==================================

# rip_fetch_queue

Instruction prefetch queue sitting directly upstream of the core's decode stage, between instruction memory and the pipeline. It generates sequential fetch addresses, issues them over a request/grant bus, collects in-order responses into a small FIFO, and presents {pc, instruction} pairs to decode through a valid/ready handshake. A redirect input from execute, on a taken branch or jump, flushes the queue and discards responses still in flight.

## Interface
- START_ADDR, 32'h00008000, fetch address after reset
- DEPTH, 4, queue entries (power of two, ≥2); also the bound on entries plus outstanding requests
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses arrive in request order, latency ≥1 cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0
- if_valid  out  1  head entry is available to decode
- if_pc  out  32  pc of the head entry
- if_inst  out  32  instruction of the head entry
- if_ready  in  1  decode consumes the head entry this cycle

## Operation
- State: fetch_pc[31:0]; FIFO of DEPTH × {pc, inst} with read and write pointers of clog2(DEPTH) bits that wrap naturally; count; outstanding (granted requests not yet responded); discard (responses still to be dropped). count, outstanding and discard are each clog2(DEPTH+1) bits wide.
- Issue: imem_req = !redirect_valid && (count + outstanding < DEPTH). imem_addr = fetch_pc.
- On req && gnt: fetch_pc += 4 (32-bit wrap), and outstanding increments.
- While req && !gnt: imem_addr holds stable.
- Response: each imem_rvalid decrements outstanding.
  - If discard ≠ 0: discard decrements and the data is dropped.
  - Otherwise: push {pc_tag, imem_rdata}. pc_tag comes from a shadow address FIFO of granted addresses, or equivalently is computed as head-of-line pc + 4·(count + pending).
- Overflow is impossible by construction, because the credit rule reserves a slot for every outstanding request.
- Dequeue: if_valid = (count ≠ 0) && !redirect_valid. if_pc and if_inst are the head entry, driven straight from FIFO storage. Pop happens on if_valid && if_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Redirect has priority over everything else.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - count and both pointers are cleared.
  - discard <= outstanding − (imem_rvalid ? 1 : 0) + discard-adjust. Every request granted before the redirect is dropped; a response arriving in the redirect cycle itself is dropped.
  - No request issues in the redirect cycle.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- imem_rvalid with outstanding = 0 is a protocol error. The simulation assertion fires and state is unchanged.

## Timing
- Reset (asynchronous assert, synchronous to clk on release):
  - fetch_pc = START_ADDR.
  - count, outstanding, discard, pointers = 0.
  - if_valid = 0, imem_req = 0.
  - if_pc and if_inst have no defined value while if_valid = 0.
- Reset asserted mid-operation drops all queue contents and all in-flight requests immediately. The memory side must also be reset.
- First cycle after release: imem_req = 1, imem_addr = START_ADDR.
- Latency with 1-cycle memory:
  - grant in cycle N;
  - rvalid in cycle N+1, written at the end of N+1;
  - if_valid in cycle N+2.
  - Total: 2 cycles from grant to visible entry. There is no bypass path.
- Throughput: 1 instruction/cycle sustained when DEPTH ≥ 3 with 1-cycle memory and if_ready held high.
- After a redirect in cycle R: request for the new pc in R+1; its entry becomes visible in R+3 at the earliest.
- Full queue with if_ready = 0: imem_req falls once count + outstanding = DEPTH. It rises in the cycle after the first pop.

## Test plan
- Reset release, 1-cycle memory, if_ready = 1:
  - imem_addr sequence is 8000, 8004, 8008, … on consecutive cycles.
  - if_valid first rises 2 cycles after the first grant.
  - (pc, inst) pairs match memory in order, one per cycle.
- Stall: hold if_ready = 0 for 10 cycles.
  - Exactly DEPTH = 4 entries are accepted and imem_req drops.
  - On release, 8000–800C drain in order, then fetch resumes at 8010 with no gap or duplicate.
- Redirect to 0x00009002 while 2 requests are outstanding:
  - both old responses are discarded;
  - the next imem_addr is 0x00009000;
  - the first if_pc after the redirect is 0x00009000.
- Redirect in the same cycle as imem_rvalid and if_ready:
  - no pop is counted;
  - the response is dropped;
  - the queue is empty in R+1.
- Random imem_gnt (50%) and variable response latency of 1–3 cycles, in order, with random redirects:
  - if_pc is strictly consecutive (+4) between redirects;
  - no entry is ever lost or duplicated;
  - count + outstanding ≤ DEPTH always.
- Assert rst while the queue is full and requests are outstanding:
  - if_valid = 0 and imem_req = 0 immediately;
  - after release, fetch restarts at 0x00008000.

Source files
------------

// File: rtl/rip_fetch_queue_if.sv
// Bundle of the instruction-memory request/grant bus, the redirect input and the
// decode-side valid/ready handshake around the fetch queue.
interface rip_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    // Fetch-queue side.
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_pc, if_inst,
        input  if_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_pc, if_inst,
        output if_ready
    );
endinterface

// File: rtl/rip_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches on a credit basis, buffers
// in-order responses as {pc, inst} and flushes on redirect, dropping stale responses.
module rip_fetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h0000_8000,
    parameter int          DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    rip_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   wr_pc_reg, wr_pc_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [CW:0] credit;
    logic [31:0] target_pc;
    logic        redirect;
    logic        grant;
    logic        rsp_ok;
    logic        push;
    logic        pop;

    assign redirect  = bus.redirect_valid;
    assign target_pc = bus.redirect_pc & ~32'd3;
    assign credit    = {1'b0, count_reg} + {1'b0, outstanding_reg};

    // Slots are reserved for every outstanding request, so a push can never overflow.
    assign bus.imem_req  = !rst && !redirect && (credit < (CW + 1)'(DEPTH));
    assign bus.imem_addr = fetch_pc_reg;
    assign bus.if_valid  = !rst && (count_reg != '0) && !redirect;
    assign bus.if_pc     = pc_mem[rd_ptr_reg];
    assign bus.if_inst   = inst_mem[rd_ptr_reg];

    assign grant  = bus.imem_req && bus.imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok = bus.imem_rvalid && (outstanding_reg != '0);
    assign push   = rsp_ok && (discard_reg == '0) && !redirect;
    assign pop    = bus.if_valid && bus.if_ready;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        wr_pc_next       = wr_pc_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg + CW'(grant) - CW'(rsp_ok);
        discard_next     = discard_reg;

        if (redirect) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_next = target_pc;
            wr_pc_next    = target_pc;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            discard_next  = outstanding_reg - CW'(rsp_ok);
        end else begin
            if (grant) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (rsp_ok && (discard_reg != '0)) begin
                discard_next = discard_reg - CW'(1);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                wr_pc_next  = wr_pc_reg + 32'd4;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= START_ADDR;
            wr_pc_reg       <= START_ADDR;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            wr_pc_reg       <= wr_pc_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    // Entry storage carries no reset; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= wr_pc_reg;
            inst_mem[wr_ptr_reg] <= bus.imem_rdata;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rvalid && (outstanding_reg == '0)));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit <= (CW + 1)'(DEPTH));
endmodule

// File: tb/tb_rip_fetch_queue.sv
// Directed bench for rip_fetch_queue with an in-order instruction memory model
// and a pc/inst scoreboard on every decode pop.
module tb_rip_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] START = 32'h0000_8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rip_fetch_queue_if bus();

    rip_fetch_queue #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          vectors;
    int          miscompares;
    int          grants;
    int          pops;
    bit          gnt_rand;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive this cycle's inputs (memory response, grant, decode, redirect) and settle.
    task automatic drive(input logic ready, input logic redir, input logic [31:0] rpc);
        bus.if_ready       = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_gnt       = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pending[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
    endtask

    // Record the handshakes of this cycle, score any pop, then move to the next cycle.
    task automatic advance();
        int d;
        if (bus.imem_rvalid) void'(pending.pop_front());
        if (bus.imem_req && bus.imem_gnt) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pending.push_back('{bus.imem_addr, d});
            grants++;
        end
        if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc & ~32'd3;
        end else if (bus.if_valid && bus.if_ready) begin
            chk("pop_pc", bus.if_pc, exp_pc);
            chk("pop_inst", bus.if_inst, mem_word(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
        chk("credit_bound", 32'(pending.size() <= DEPTH), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset (memory side included), check outputs at once, release after two edges.
    task automatic do_reset();
        rst                = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        pending.delete();
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        last_due = -1;
        exp_pc   = START;
        grants   = 0;
        pops     = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        gnt_rand    = 1'b0;
        lat_min     = 1;
        lat_max     = 1;

        // Streaming from reset with 1-cycle memory and decode always ready.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 32'd0);
            chk("seq_req", 32'(bus.imem_req), 32'd1);
            chk("seq_addr", bus.imem_addr, START + 32'(4 * c));
            chk("seq_valid", 32'(bus.if_valid), 32'(c >= 2));
            advance();
        end

        // Decode stall: four entries fill the queue, then drain and resume.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, 32'd0);
            chk("stall_req", 32'(bus.imem_req), 32'(c < 4));
            if (c == 9) begin
                chk("stall_head_valid", 32'(bus.if_valid), 32'd1);
                chk("stall_head_pc", bus.if_pc, START);
            end
            advance();
        end
        chk("stall_grants", 32'(grants), 32'd4);
        for (int c = 10; c < 15; c++) begin
            drive(1'b1, 1'b0, 32'd0);
            chk("resume_req", 32'(bus.imem_req), 32'(c >= 11));
            if (c == 11) chk("resume_addr", bus.imem_addr, 32'h0000_8010);
            advance();
        end
        chk("drain_pops", 32'(pops), 32'd5);

        // Redirect with two requests outstanding (2-cycle memory).
        do_reset();
        lat_min = 2;
        lat_max = 2;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 32'd0);
            if (c == 2) begin
                drive(1'b1, 1'b1, 32'h0000_9002);
                chk("redir_req", 32'(bus.imem_req), 32'd0);
                chk("redir_valid", 32'(bus.if_valid), 32'd0);
            end
            if (c == 3) chk("redir_addr", bus.imem_addr, 32'h0000_9000);
            if (c >= 3 && c <= 5) chk("redir_empty", 32'(bus.if_valid), 32'd0);
            if (c == 6) begin
                chk("redir_first_valid", 32'(bus.if_valid), 32'd1);
                chk("redir_first_pc", bus.if_pc, 32'h0000_9000);
            end
            advance();
        end

        // Redirect coinciding with a response and a ready decode.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                drive(1'b1, 1'b1, 32'h0000_A001);
                chk("same_rvalid_seen", 32'(bus.imem_rvalid), 32'd1);
                chk("same_valid", 32'(bus.if_valid), 32'd0);
            end else begin
                drive(1'b1, 1'b0, 32'd0);
            end
            if (c == 3) begin
                chk("same_empty", 32'(bus.if_valid), 32'd0);
                chk("same_addr", bus.imem_addr, 32'h0000_A000);
                chk("same_nopop", 32'(pops), 32'd0);
            end
            if (c == 5) begin
                chk("same_first_valid", 32'(bus.if_valid), 32'd1);
                chk("same_first_pc", bus.if_pc, 32'h0000_A000);
            end
            advance();
        end

        // Random grant, 1..3 cycle latency, random decode stalls and redirects.
        do_reset();
        gnt_rand = 1'b1;
        lat_min  = 1;
        lat_max  = 3;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), $urandom);
            advance();
        end
        chk("rand_progress", 32'(pops > 20), 32'd1);

        // Reset while credits are exhausted and responses are in flight.
        do_reset();
        gnt_rand = 1'b0;
        lat_min  = 3;
        lat_max  = 3;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 32'd0);
            advance();
        end
        drive(1'b0, 1'b0, 32'd0);
        chk("pre_rst_valid", 32'(bus.if_valid), 32'd1);
        chk("pre_rst_req", 32'(bus.imem_req), 32'd0);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 32'd0);
            if (c == 0) begin
                chk("restart_req", 32'(bus.imem_req), 32'd1);
                chk("restart_addr", bus.imem_addr, START);
            end
            if (c == 2) chk("restart_pc", bus.if_pc, START);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
